// File: rtl/seg7_scan_rx.sv
// Receiver for a multiplexed 4-digit 7-segment scan: captures stable digits, assembles frames.
// Build option: define SEG7_SCAN_RX_DECODE_EN to register a 5-bit symbol per digit on code.
module seg7_scan_rx #(
   parameter int STABLE_CYC  = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        dp,
   output logic [31:0] frame,
   output logic [19:0] code,
   output logic        valid,
   input  logic        ready,
   output logic        err,
   output logic        overrun
);

   localparam logic [0:0]  ST_SYNC    = 1'b0;
   localparam logic [0:0]  ST_COLLECT = 1'b1;
   localparam logic [7:0]  STABLE_V   = 8'(STABLE_CYC);
   localparam logic [16:0] TIMEOUT_V  = 17'(TIMEOUT_CYC);

   logic [11:0] sample_s;
   logic [7:0]  pattern_s;
   logic [11:0] prev_r;
   logic [7:0]  stab_r;
   logic [7:0]  stab_next_s;
   logic        same_s;
   logic        capture_s;
   logic        legal_s;
   logic        illegal_s;
   logic [1:0]  idx_s;
   logic [0:0]  state_r;
   logic [0:0]  state_n_s;
   logic [1:0]  exp_r;
   logic [1:0]  exp_n_s;
   logic [15:0] tmo_r;
   logic [15:0] tmo_n_s;
   logic [31:0] shadow_r;
   logic [31:0] shadow_n_s;
   logic        complete_s;
   logic        load_s;
   logic        err_s;
   logic [31:0] frame_r;
   logic        valid_r;
   logic        err_r;
   logic        overrun_r;

   assign sample_s  = {an, dp, seg};
   assign pattern_s = {dp, seg};

   // Stability run length; stab_r == 0 marks "no previous sample" after reset.
   always_comb begin
      same_s      = (stab_r != 8'd0) && (sample_s == prev_r);
      stab_next_s = 8'd1;
      if (same_s) begin
         if (stab_r == STABLE_V) begin
            stab_next_s = stab_r;
         end else begin
            stab_next_s = stab_r + 8'd1;
         end
      end else begin
         stab_next_s = 8'd1;
      end
      capture_s = (stab_next_s == STABLE_V) && (!same_s || (stab_r != STABLE_V));
   end

   // Classify the digit enables.
   always_comb begin
      legal_s   = 1'b0;
      illegal_s = 1'b0;
      idx_s     = 2'd0;
      case (an)
         4'b1110: begin legal_s = 1'b1; idx_s = 2'd0; end
         4'b1101: begin legal_s = 1'b1; idx_s = 2'd1; end
         4'b1011: begin legal_s = 1'b1; idx_s = 2'd2; end
         4'b0111: begin legal_s = 1'b1; idx_s = 2'd3; end
         4'b1111: begin legal_s = 1'b0; illegal_s = 1'b0; end
         default: illegal_s = 1'b1;
      endcase
   end

   // Frame sequencing: digit order, shadow storage and inter-capture timeout.
   always_comb begin
      state_n_s  = state_r;
      exp_n_s    = exp_r;
      tmo_n_s    = tmo_r;
      shadow_n_s = shadow_r;
      complete_s = 1'b0;
      err_s      = 1'b0;
      if (capture_s && illegal_s) begin
         err_s     = 1'b1;
         state_n_s = ST_SYNC;
         tmo_n_s   = 16'd0;
      end else if (capture_s && legal_s) begin
         tmo_n_s = 16'd0;
         if (state_r == ST_SYNC) begin
            if (idx_s == 2'd0) begin
               shadow_n_s[7:0] = pattern_s;
               state_n_s       = ST_COLLECT;
               exp_n_s         = 2'd1;
            end else begin
               state_n_s = ST_SYNC;
            end
         end else if (idx_s == exp_r) begin
            shadow_n_s[{idx_s, 3'b000} +: 8] = pattern_s;
            if (idx_s == 2'd3) begin
               complete_s = 1'b1;
               state_n_s  = ST_SYNC;
            end else begin
               exp_n_s = exp_r + 2'd1;
            end
         end else begin
            // Out-of-order digit: a stray digit 0 restarts the frame instead of waiting for resync.
            err_s = 1'b1;
            if (idx_s == 2'd0) begin
               shadow_n_s[7:0] = pattern_s;
               state_n_s       = ST_COLLECT;
               exp_n_s         = 2'd1;
            end else begin
               state_n_s = ST_SYNC;
            end
         end
      end else if (state_r == ST_COLLECT) begin
         if (({1'b0, tmo_r} + 17'd1) >= TIMEOUT_V) begin
            err_s     = 1'b1;
            state_n_s = ST_SYNC;
            tmo_n_s   = 16'd0;
         end else begin
            tmo_n_s = tmo_r + 16'd1;
         end
      end else begin
         tmo_n_s = 16'd0;
      end
   end

   assign load_s = complete_s && (!valid_r || ready);

   // Sampling and sequencing state.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r   <= 12'hFFF;
         stab_r   <= 8'd0;
         state_r  <= ST_SYNC;
         exp_r    <= 2'd0;
         tmo_r    <= 16'd0;
         shadow_r <= 32'hFFFF_FFFF;
         err_r    <= 1'b0;
      end else begin
         prev_r   <= sample_s;
         stab_r   <= stab_next_s;
         state_r  <= state_n_s;
         exp_r    <= exp_n_s;
         tmo_r    <= tmo_n_s;
         shadow_r <= shadow_n_s;
         err_r    <= err_s;
      end
   end

   // Output holding register with valid/ready handshake and overrun detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_r   <= 32'hFFFF_FFFF;
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= 1'b0;
         if (load_s) begin
            frame_r <= {pattern_s, shadow_r[23:0]};
            valid_r <= 1'b1;
         end else if (complete_s) begin
            overrun_r <= 1'b1;
         end else if (ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

`ifdef SEG7_SCAN_RX_DECODE_EN
   logic [19:0] code_r;

   function automatic logic [4:0] decode_sym(input logic [7:0] p);
      logic [4:0] c;
      case (p)
         8'hFF: c = 5'd0;
         8'h88: c = 5'd1;
         8'h83: c = 5'd2;
         8'hC6: c = 5'd3;
         8'hA1: c = 5'd4;
         8'h86: c = 5'd5;
         8'h8E: c = 5'd6;
         8'hC2: c = 5'd7;
         8'h8B: c = 5'd8;
         8'hFB: c = 5'd9;
         8'hE1: c = 5'd10;
         8'h8A: c = 5'd11;
         8'hC7: c = 5'd12;
         8'hC8: c = 5'd13;
         8'hAB: c = 5'd14;
         8'hA3: c = 5'd15;
         8'h8C: c = 5'd16;
         8'h98: c = 5'd17;
         8'hAF: c = 5'd18;
         8'h93: c = 5'd19;
         8'h87: c = 5'd20;
         8'hE3: c = 5'd21;
         8'hC1: c = 5'd22;
         8'h81: c = 5'd23;
         8'h89: c = 5'd24;
         8'h91: c = 5'd25;
         8'hE4: c = 5'd26;
         8'hBF: c = 5'd27;
         default: c = 5'd31;
      endcase
      return c;
   endfunction

   // Decoded symbols load in step with frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_r <= 20'h0;
      end else if (load_s) begin
         code_r <= {decode_sym(pattern_s), decode_sym(shadow_r[23:16]),
                    decode_sym(shadow_r[15:8]), decode_sym(shadow_r[7:0])};
      end else begin
         code_r <= code_r;
      end
   end

   assign code = code_r;
`else
   assign code = 20'h0;
`endif

   assign frame   = frame_r;
   assign valid   = valid_r;
   assign err     = err_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: directed frame table, corner sequences and a randomized scan
// checked every cycle against a run-length/sequence reference model.
module tb_seg7_scan_rx;

   localparam int STABLE  = 2;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [31:0] frame;
   logic [19:0] code;
   logic        valid;
   logic        ready;
   logic        err;
   logic        overrun;

   seg7_scan_rx #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp), .frame(frame), .code(code),
      .valid(valid), .ready(ready), .err(err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pats;
      logic [31:0] exp_frame;
      logic [19:0] exp_code;
   } vec_t;

   vec_t tbl[4];
   logic [7:0] sym_tab[28];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int         m_last, m_run, m_exp, m_since;
   logic [7:0] m_sh[4];
   logic       m_valid, m_err, m_ovr;
   logic [31:0] m_frame;
   logic [19:0] m_code;

   // observations
   int          obs_err, obs_ovr, obs_vcyc;
   logic [31:0] obs_frame;
   logic [19:0] obs_code;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   function automatic logic [4:0] ref_code(input logic [7:0] p);
      for (int i = 0; i < 28; i++)
         if (sym_tab[i] == p) return 5'(i);
      return 5'd31;
   endfunction

   function automatic logic [3:0] oh(input int k);
      logic [3:0] v;
      v = 4'b0001 << k;
      return ~v;
   endfunction

   task automatic model_step(input logic [3:0] a, input logic [7:0] p, input logic r, input logic rs);
      int  k;
      int  smp;
      bit  done;
      m_err = 1'b0;
      m_ovr = 1'b0;
      done  = 1'b0;
      if (rs) begin
         m_last = -1; m_run = 0; m_exp = -1; m_since = 0;
         for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
         m_valid = 1'b0; m_frame = 32'hFFFF_FFFF; m_code = 20'h0;
         return;
      end
      smp = int'({a, p});
      m_run  = (smp == m_last) ? m_run + 1 : 1;
      m_last = smp;
      k = -1;
      for (int i = 0; i < 4; i++) if (a == oh(i)) k = i;
      if (m_run == STABLE && a != 4'hF && k < 0) begin
         m_err = 1'b1; m_exp = -1;
      end else if (m_run == STABLE && k >= 0) begin
         m_since = 0;
         if (m_exp < 0) begin
            if (k == 0) begin m_sh[0] = p; m_exp = 1; end
         end else if (k == m_exp) begin
            m_sh[k] = p;
            if (k == 3) begin done = 1'b1; m_exp = -1; end
            else m_exp = m_exp + 1;
         end else begin
            m_err = 1'b1;
            if (k == 0) begin m_sh[0] = p; m_exp = 1; end
            else m_exp = -1;
         end
      end else if (m_exp >= 0) begin
         m_since++;
         if (m_since == TIMEOUT) begin m_err = 1'b1; m_exp = -1; end
      end
      if (done) begin
         if (!m_valid || r) begin
            m_frame = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
`ifdef SEG7_SCAN_RX_DECODE_EN
            m_code = {ref_code(m_sh[3]), ref_code(m_sh[2]), ref_code(m_sh[1]), ref_code(m_sh[0])};
`else
            m_code = 20'h0;
`endif
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (r) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic clr_obs();
      obs_err = 0; obs_ovr = 0; obs_vcyc = 0; obs_frame = 32'h0; obs_code = 20'h0;
   endtask

   task automatic cycle(input logic [3:0] a, input logic [7:0] p, input logic r, input logic rs);
      an = a; dp = p[7]; seg = p[6:0]; ready = r; rst = rs;
      model_step(a, p, r, rs);
      @(posedge clk);
      #1;
      check("valid", 32'(valid), 32'(m_valid));
      check("err", 32'(err), 32'(m_err));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("frame", frame, m_frame);
      check("code", 32'(code), 32'(m_code));
      if (err) obs_err++;
      if (overrun) obs_ovr++;
      if (valid) begin obs_vcyc++; obs_frame = frame; obs_code = code; end
   endtask

   task automatic hold(input logic [3:0] a, input logic [7:0] p, input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(a, p, r, 1'b0);
   endtask

   task automatic scan(input logic [31:0] pats, input int n, input logic r);
      for (int k = 0; k < 4; k++) hold(oh(k), pats[8*k +: 8], n, r);
   endtask

   task automatic do_reset();
      cycle(4'hF, 8'hFF, 1'b0, 1'b1);
      clr_obs();
   endtask

   initial begin
      logic [19:0] exp_c;
      int          err_at;
      sym_tab = '{8'hFF, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h8B, 8'hFB,
                  8'hE1, 8'h8A, 8'hC7, 8'hC8, 8'hAB, 8'hA3, 8'h8C, 8'h98, 8'hAF, 8'h93,
                  8'h87, 8'hE3, 8'hC1, 8'h81, 8'h89, 8'h91, 8'hE4, 8'hBF};
      tbl[0] = '{32'h86AF_E3C6, 32'h86AF_E3C6, {5'd5, 5'd18, 5'd21, 5'd3}};
      tbl[1] = '{32'hBFFF_8388, 32'hBFFF_8388, {5'd27, 5'd0, 5'd2, 5'd1}};
      tbl[2] = '{32'hE4C8_1200, 32'hE4C8_1200, {5'd26, 5'd13, 5'd31, 5'd31}};
      tbl[3] = '{32'h91E1_FB7F, 32'h91E1_FB7F, {5'd25, 5'd10, 5'd9, 5'd31}};

      an = 4'hF; dp = 1'b1; seg = 7'h7F; ready = 1'b0; rst = 1'b1;
      do_reset();
      do_reset();
      check("rst_frame", frame, 32'hFFFF_FFFF);
      check("rst_code", 32'(code), 32'h0);
      check("rst_flags", 32'({valid, err, overrun}), 32'h0);

      // frame table, ready=1: one-cycle valid pulse with the expected contents
      for (int i = 0; i < 4; i++) begin
         do_reset();
         scan(tbl[i].pats, (i == 0) ? 4 : 3, 1'b1);
         hold(4'hF, 8'hFF, 2, 1'b1);
`ifdef SEG7_SCAN_RX_DECODE_EN
         exp_c = tbl[i].exp_code;
`else
         exp_c = 20'h0;
`endif
         check("tbl_vcyc", 32'(obs_vcyc), 32'd1);
         check("tbl_frame", obs_frame, tbl[i].exp_frame);
         check("tbl_code", 32'(obs_code), 32'(exp_c));
         check("tbl_err", 32'(obs_err), 32'd0);
      end

      // out-of-order digit then clean scan
      do_reset();
      hold(oh(0), 8'hC6, 3, 1'b1);
      hold(oh(2), 8'hAF, 3, 1'b1);
      check("seq_err", 32'(obs_err), 32'd1);
      scan(tbl[0].pats, 3, 1'b1);
      hold(4'hF, 8'hFF, 2, 1'b1);
      check("seq_err_total", 32'(obs_err), 32'd1);
      check("seq_vcyc", 32'(obs_vcyc), 32'd1);
      check("seq_frame", obs_frame, 32'h86AF_E3C6);

      // two frames without ready: second dropped
      do_reset();
      scan(tbl[0].pats, 3, 1'b0);
      scan(tbl[1].pats, 3, 1'b0);
      check("ovr_count", 32'(obs_ovr), 32'd1);
      check("ovr_frame", frame, 32'h86AF_E3C6);
      check("ovr_valid", 32'(valid), 32'd1);
      hold(4'hF, 8'hFF, 2, 1'b1);
      check("ovr_release", 32'(valid), 32'd0);

      // timeout after digit 0
      do_reset();
      hold(oh(0), 8'hC6, STABLE, 1'b1);
      err_at = 0;
      for (int i = 1; i <= TIMEOUT + 2; i++) begin
         cycle(4'hF, 8'hFF, 1'b1, 1'b0);
         if (err && err_at == 0) err_at = i;
      end
      check("tmo_cycle", 32'(err_at), 32'(TIMEOUT));
      clr_obs();
      for (int k = 1; k < 4; k++) hold(oh(k), 8'h88, 3, 1'b1);
      check("tmo_sync_err", 32'(obs_err), 32'd0);
      check("tmo_sync_valid", 32'(obs_vcyc), 32'd0);

      // illegal an held
      do_reset();
      hold(4'b1100, 8'h88, 3, 1'b1);
      check("ill_err", 32'(obs_err), 32'd1);
      for (int k = 1; k < 4; k++) hold(oh(k), 8'h88, 3, 1'b1);
      check("ill_nocap", 32'(obs_vcyc), 32'd0);

      // reset mid-frame with a held frame present
      do_reset();
      scan(tbl[1].pats, 3, 1'b0);
      for (int k = 0; k < 3; k++) hold(oh(k), 8'hA1, 3, 1'b0);
      do_reset();
      check("mid_rst_frame", frame, 32'hFFFF_FFFF);
      check("mid_rst_code", 32'(code), 32'h0);
      check("mid_rst_flags", 32'({valid, err, overrun}), 32'h0);
      scan(tbl[0].pats, 3, 1'b1);
      hold(4'hF, 8'hFF, 2, 1'b1);
      check("mid_rst_after", obs_frame, 32'h86AF_E3C6);
      check("mid_rst_err", 32'(obs_err + obs_ovr), 32'd0);

      // randomized scans against the reference model
      begin
         int         dptr;
         int         r;
         int         n;
         logic [3:0] a;
         logic [7:0] p;
         dptr = 0;
         for (int h = 0; h < 700; h++) begin
            r = $urandom_range(0, 99);
            p = ($urandom_range(0, 1) == 0) ? sym_tab[$urandom_range(0, 27)] : 8'($urandom);
            n = $urandom_range(1, 5);
            if (r < 70) begin
               a = oh(dptr); dptr = (dptr + 1) % 4;
            end else if (r < 80) begin
               a = oh($urandom_range(0, 3));
            end else if (r < 90) begin
               a = 4'hF; n = $urandom_range(1, 20);
            end else if (r < 98) begin
               a = 4'($urandom_range(0, 15));
               if (a == 4'hF || a == 4'hE || a == 4'hD || a == 4'hB || a == 4'h7) a = 4'h0;
            end else begin
               a = 4'hF;
               cycle(a, p, 1'b0, 1'b1);
               n = 0;
            end
            for (int i = 0; i < n; i++) cycle(a, p, ($urandom_range(0, 3) != 0), 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
